// File: rtl/rf_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_loader_pkg
// Purpose  : Shared definitions for the register-file stream loader: the FSM
//            state encoding and the default register-file geometry, reused by
//            the register file itself and by benches.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rf_loader_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_loader_wr_stage.sv
`default_nettype none
// ============================================================================
// Module   : rf_loader_wr_stage
// Purpose  : Registered write stage of the loader. A transfer strobe in one
//            cycle becomes a single-cycle register-file write in the next.
//            When SKIP_R0 is set, the word destined for address 0 is absorbed
//            without raising the write enable (r0 is hardwired zero).
// Ports    : clk, rstb          - clock, async active-low reset
//            xfer               - stream handshake completed this cycle
//            ptr, data          - destination address and word of the transfer
//            rf_we/rf_waddr/rf_wdata - register-file write port
// Revision : 1.0 - initial release
// ============================================================================
module rf_loader_wr_stage #(
  parameter int AW      = 5,
  parameter int DATA_W  = 32,
  parameter int SKIP_R0 = 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              xfer,
  input  logic [AW-1:0]     ptr,
  input  logic [DATA_W-1:0] data,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  logic              w_we_next;
  logic              r_we;
  logic [AW-1:0]     r_waddr;
  logic [DATA_W-1:0] r_wdata;

  generate
    if (SKIP_R0 != 0) begin : g_skip_r0
      assign w_we_next = xfer && (ptr != '0);
    end else begin : g_no_skip
      assign w_we_next = xfer;
    end
  endgenerate

  // Address/data are captured for every transfer, including a skipped r0
  // word; without the enable they are never committed.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_we_next;
      if (xfer) begin
        r_waddr <= ptr;
        r_wdata <= data;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/rf_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : rf_stream_loader
// Purpose  : Fills the core register file r0..r(NUM_REGS-1) from a valid/ready
//            word stream before execution starts, holding the core halted for
//            the duration of the load.
// Ports    : clk, rstb                 - clock, async active-low reset
//            start, abort              - sequence control (levels)
//            in_valid/in_data/in_ready - input word stream
//            rf_we/rf_waddr/rf_wdata   - register-file load port
//            core_halt, busy           - high while a sequence is active
//            done                      - one-cycle pulse on completion
//            aborted                   - sticky abort flag, cleared by start
//            words_loaded              - words accepted this/last sequence
//            checksum (optional)       - running sum of accepted words
// Config   : define RF_LOADER_CHECKSUM_EN to add the checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module rf_stream_loader
  import rf_loader_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int SKIP_R0  = 1
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        rf_we,
  output logic [$clog2(NUM_REGS)-1:0] rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic                        core_halt,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic [$clog2(NUM_REGS):0]   words_loaded
`ifdef RF_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]           checksum
`endif
);

  localparam int              AW          = $clog2(NUM_REGS);
  localparam logic [AW-1:0]   c_last_ptr  = AW'(NUM_REGS - 1);
  localparam logic [AW:0]     c_words_max = (AW+1)'(NUM_REGS);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_words;
  logic          r_done;
  logic          r_aborted;
  logic          w_in_ready;
  logic          w_xfer;
  logic          w_seq_start;

  // Abort blocks the handshake in the same cycle, so no word is consumed on
  // the cycle the sequence is torn down.
  always_comb begin
    w_in_ready   = (r_state == LOAD) && !abort;
    w_xfer       = in_valid && w_in_ready;
    w_seq_start  = (r_state == IDLE) && start;
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = LOAD;
      LOAD: begin
        if (abort)                              w_state_next = IDLE;
        else if (w_xfer && r_ptr == c_last_ptr) w_state_next = FLUSH;
      end
      FLUSH:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_words   <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // FLUSH always returns to IDLE, so leaving it is the completion event.
      r_done  <= (r_state == FLUSH);
      if (w_seq_start) begin
        r_ptr     <= '0;
        r_words   <= '0;
        r_aborted <= 1'b0;
      end else begin
        if (w_xfer) begin
          r_ptr <= r_ptr + AW'(1);
          if (r_words != c_words_max) r_words <= r_words + (AW+1)'(1);
        end
        if ((r_state == LOAD) && abort) r_aborted <= 1'b1;
      end
    end
  end

`ifdef RF_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Every accepted word is summed, including the r0 word that is not written.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_checksum <= '0;
    end else if (w_seq_start) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum + in_data;
    end
  end

  assign checksum = r_checksum;
`endif

  rf_loader_wr_stage #(
    .AW      (AW),
    .DATA_W  (DATA_W),
    .SKIP_R0 (SKIP_R0)
  ) u_wr_stage (
    .clk      (clk),
    .rstb     (rstb),
    .xfer     (w_xfer),
    .ptr      (r_ptr),
    .data     (in_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  assign in_ready     = w_in_ready;
  assign busy         = (r_state != IDLE);
  assign core_halt    = (r_state != IDLE);
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_rf_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_stream_loader
// Purpose  : Self-checking bench for rf_stream_loader. A cycle model predicts
//            the control outputs; expected register writes are queued when a
//            handshake is driven and popped when the DUT raises rf_we.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_stream_loader;

  localparam int NUM_REGS = rf_loader_pkg::RF_NUM_REGS;
  localparam int DATA_W   = rf_loader_pkg::RF_DATA_W;
  localparam int SKIP_R0  = 1;
  localparam int AW       = $clog2(NUM_REGS);

  typedef struct {
    int                addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk      = 1'b0;
  logic              rstb     = 1'b1;
  logic              start    = 1'b0;
  logic              abort    = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_ready;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              core_halt;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [AW:0]       words_loaded;
`ifdef RF_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  always #5 clk = ~clk;

  rf_stream_loader #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .SKIP_R0  (SKIP_R0)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .core_halt    (core_halt),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .words_loaded (words_loaded)
`ifdef RF_LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  wr_t               sb_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  // model: 0 = IDLE, 1 = LOAD, 2 = FLUSH
  int                m_state = 0;
  int                m_ptr   = 0;
  int                m_words = 0;
  bit                m_aborted = 1'b0;
  bit                m_done    = 1'b0;
  logic [DATA_W-1:0] m_sum     = '0;
  bit                last_xfer = 1'b0;
  int                cyc = 0;
  int                n_writes = 0;
  int                n_done = 0;
  int                done_cyc = 0;
  int                prev_done_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_ptr     = 0;
    m_words   = 0;
    m_aborted = 1'b0;
    m_done    = 1'b0;
    m_sum     = '0;
    sb_q.delete();
  endtask

  task automatic check_zero(input string p);
    check_eq({p, "_in_ready"},  32'(in_ready),     32'd0);
    check_eq({p, "_rf_we"},     32'(rf_we),        32'd0);
    check_eq({p, "_rf_waddr"},  32'(rf_waddr),     32'd0);
    check_eq({p, "_rf_wdata"},  32'(rf_wdata),     32'd0);
    check_eq({p, "_core_halt"}, 32'(core_halt),    32'd0);
    check_eq({p, "_busy"},      32'(busy),         32'd0);
    check_eq({p, "_done"},      32'(done),         32'd0);
    check_eq({p, "_aborted"},   32'(aborted),      32'd0);
    check_eq({p, "_words"},     32'(words_loaded), 32'd0);
  endtask

  // Called just after a falling edge: apply inputs, predict the coming rising
  // edge, then check everything at the next falling edge.
  task automatic tick(input bit v, input logic [DATA_W-1:0] d, input bit s, input bit a);
    bit exp_ready;
    int nstate;
    wr_t e;
    in_valid = v;
    in_data  = d;
    start    = s;
    abort    = a;
    #1;
    exp_ready = (m_state == 1) && !a;
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    last_xfer = v && exp_ready;
    nstate = m_state;
    m_done = 1'b0;
    case (m_state)
      0: if (s) begin
        nstate = 1; m_ptr = 0; m_words = 0; m_aborted = 1'b0; m_sum = '0;
      end
      1: if (a) begin
        nstate = 0; m_aborted = 1'b1;
      end else if (last_xfer) begin
        if (!(SKIP_R0 != 0 && m_ptr == 0)) sb_q.push_back('{m_ptr, d});
        m_sum = m_sum + d;
        if (m_words < NUM_REGS) m_words++;
        if (m_ptr == NUM_REGS - 1) nstate = 2;
        m_ptr++;
      end
      default: begin
        nstate = 0; m_done = 1'b1;
      end
    endcase
    m_state = nstate;
    @(negedge clk);
    cyc++;
    if (rf_we) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        check_eq("rf_we_spurious", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("wr_addr", 32'(rf_waddr), 32'(e.addr));
        check_eq("wr_data", rf_wdata, e.data);
      end
    end
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    check_eq("done", 32'(done), 32'(m_done));
    if (done) begin
      n_done++;
      prev_done_cyc = done_cyc;
      done_cyc = cyc;
    end
    check_eq("busy",      32'(busy),         32'(m_state != 0));
    check_eq("core_halt", 32'(core_halt),    32'(m_state != 0));
    check_eq("aborted",   32'(aborted),      32'(m_aborted));
    check_eq("words",     32'(words_loaded), 32'(m_words));
`ifdef RF_LOADER_CHECKSUM_EN
    check_eq("checksum",  checksum,          m_sum);
`endif
  endtask

  task automatic run_load(input logic [DATA_W-1:0] base, input bit throttle,
                          input bit fixed, input bit chk_latency);
    int t0, w0, d0;
    bit v;
    t0 = cyc; w0 = n_writes; d0 = n_done;
    tick(1'b1, base, 1'b1, 1'b0);
    for (int i = 0; i < 200 && m_state != 0; i++) begin
      v = throttle ? i[0] : 1'b1;
      tick(v, fixed ? base : base + 32'(m_ptr), 1'b0, 1'b0);
    end
    check_eq("load_end_busy", 32'(busy), 32'd0);
    check_eq("load_done_cnt", 32'(n_done - d0), 32'd1);
    check_eq("load_writes", 32'(n_writes - w0), 32'(NUM_REGS - 1));
    check_eq("load_words", 32'(words_loaded), 32'(NUM_REGS));
    if (chk_latency) check_eq("done_latency", 32'(done_cyc - t0), 32'd34);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w0, d0, offered;

    // reset state
    #1 rstb = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rstb = 1'b1;
    tick(1'b0, '0, 1'b0, 1'b0);

    // full load, valid always high
    run_load(32'h1000_0000, 1'b0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0);
    check_eq("full_words_hold", 32'(words_loaded), 32'd32);

    // throttled stream; in_ready low while idle with valid asserted
    tick(1'b1, 32'h5555_0000, 1'b0, 1'b0);
    check_eq("idle_in_ready", 32'(in_ready), 32'd0);
    run_load(32'h3000_0000, 1'b1, 1'b0, 1'b0);

    // abort after 10 words, then a clean reload
    w0 = n_writes; d0 = n_done;
    tick(1'b1, 32'h4000_0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 32'h4000_0000 + 32'(m_ptr), 1'b0, 1'b0);
    tick(1'b1, 32'h4000_0000 + 32'(m_ptr), 1'b0, 1'b1);
    check_eq("abort_words", 32'(words_loaded), 32'd10);
    check_eq("abort_flag", 32'(aborted), 32'd1);
    check_eq("abort_halt", 32'(core_halt), 32'd0);
    check_eq("abort_writes", 32'(n_writes - w0), 32'd9);
    check_eq("abort_no_done", 32'(n_done - d0), 32'd0);
    tick(1'b0, '0, 1'b0, 1'b1);
    check_eq("abort_idle_ignored", 32'(aborted), 32'd1);
    run_load(32'h1000_0000, 1'b0, 1'b0, 1'b1);
    check_eq("reload_aborted_clr", 32'(aborted), 32'd0);

    // reset pulse mid-load after word 5
    tick(1'b1, 32'h6000_0000, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_words < 5; i++)
      tick(1'b1, 32'h6000_0000 + 32'(m_ptr), 1'b0, 1'b0);
    check_eq("pre_rst_words", 32'(words_loaded), 32'd5);
    #1 rstb = 1'b0;
    #1 check_zero("rst_async");
    model_reset();
    @(posedge clk);
    #1 check_eq("rst_hold_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    cyc++;
    rstb = 1'b1;
    w0 = n_writes;
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h6000_0000, 1'b0, 1'b0);
    check_eq("post_rst_writes", 32'(n_writes - w0), 32'd0);

    // start held for 80 cycles, 64 words offered
    d0 = n_done; offered = 0;
    for (int i = 0; i < 80; i++) begin
      tick(offered < 64, 32'h2000_0000 + 32'(m_ptr), 1'b1, 1'b0);
      if (last_xfer) offered++;
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0);
    check_eq("held_words_taken", 32'(offered), 32'd64);
    check_eq("held_done_cnt", 32'(n_done - d0), 32'd2);
    check_eq("held_done_gap", 32'(done_cyc - prev_done_cyc), 32'd34);

`ifdef RF_LOADER_CHECKSUM_EN
    run_load(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    check_eq("checksum_final", checksum, 32'hFFFF_FFE0);
    tick(1'b0, '0, 1'b0, 1'b0);
    check_eq("checksum_hold", checksum, 32'hFFFF_FFE0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
